// File: rtl/uart_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_pkg : shared encodings and constants for the configurable UART.
// Rev 1.0
// ----------------------------------------------------------------------------
package uart_pkg;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_ODD  = 2'b01;
  localparam logic [1:0] PAR_EVEN = 2'b10;

  localparam int MIN_DIV = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  // Mode 2'b11 is reserved and behaves as no parity.
  function automatic logic parity_enabled(input logic [1:0] mode);
    return (mode == PAR_ODD) || (mode == PAR_EVEN);
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_sync_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_sync_fifo : single-clock FIFO with registered full flag and level.
// Rev 1.0
// ----------------------------------------------------------------------------
module uart_sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [LW-1:0]    level_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [LW-1:0]    level_q;
  logic [LW-1:0]    level_d;
  logic             full_q;
  logic             w_push;
  logic             w_pop;

  // A push while full is dropped even if a pop happens on the same edge.
  assign w_push = push_i && !full_q;
  assign w_pop  = pop_i && (level_q != '0);

  always_comb begin
    level_d = level_q;
    case ({w_push, w_pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
    end else begin
      level_q <= level_d;
      full_q  <= (level_d == LW'(DEPTH));
      if (w_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (w_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign full_o  = full_q;
  assign empty_o = (level_q == '0);
  assign level_o = level_q;

endmodule
`default_nettype wire

// File: rtl/uart_tx_fifo_cfg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_tx_fifo_cfg : buffered UART transmitter, runtime baud/parity/stop cfg.
// Rev 1.0
// ----------------------------------------------------------------------------
module uart_tx_fifo_cfg
  import uart_pkg::*;
#(
  parameter  int DATA_BITS  = 8,
  parameter  int FIFO_DEPTH = 4,
  parameter  int DIV_W      = 16,
  localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1,
  localparam int BIT_W      = $clog2(DATA_BITS)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_valid_i,
  input  logic [DATA_BITS-1:0] in_data_i,
  output logic                 in_ready_o,
  input  logic [DIV_W-1:0]     baud_div_i,
  input  logic [1:0]           parity_mode_i,
  input  logic                 two_stop_i,
  output logic                 tx_o,
  output logic                 busy_o,
  output logic                 frame_done_o,
  output logic [LVL_W-1:0]     fifo_level_o
);

  logic [DATA_BITS-1:0] w_fifo_data;
  logic                 w_fifo_full;
  logic                 w_fifo_empty;
  logic                 w_pop;

  uart_sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (in_valid_i),
    .data_i  (in_data_i),
    .pop_i   (w_pop),
    .data_o  (w_fifo_data),
    .full_o  (w_fifo_full),
    .empty_o (w_fifo_empty),
    .level_o (fifo_level_o)
  );

  tx_state_e            state_q, state_d;
  logic [DIV_W-1:0]     cnt_q, cnt_d;
  logic [DIV_W-1:0]     div_q, div_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 par_q, par_d;
  logic [1:0]           pmode_q, pmode_d;
  logic                 two_stop_q, two_stop_d;
  logic                 stop_q, stop_d;
  logic                 tx_q, tx_d;
  logic                 frame_done_q, frame_done_d;
  logic                 busy_q;
  logic [DIV_W-1:0]     w_div_clamped;
  logic                 w_bit_end;

  assign w_div_clamped = (baud_div_i < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : baud_div_i;
  assign w_bit_end     = (cnt_q == (div_q - 1'b1));

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    div_d        = div_q;
    bit_d        = bit_q;
    shreg_d      = shreg_q;
    par_d        = par_q;
    pmode_d      = pmode_q;
    two_stop_d   = two_stop_q;
    stop_d       = stop_q;
    tx_d         = tx_q;
    frame_done_d = 1'b0;
    w_pop        = 1'b0;

    if (state_q != ST_IDLE) cnt_d = w_bit_end ? '0 : cnt_q + 1'b1;

    // The line level for each bit is loaded on the first cycle of that bit.
    case (state_q)
      ST_IDLE: begin
        tx_d  = 1'b1;
        cnt_d = '0;
        if (!w_fifo_empty) begin
          w_pop      = 1'b1;
          shreg_d    = w_fifo_data;
          par_d      = (parity_mode_i == PAR_ODD) ? ~^w_fifo_data : ^w_fifo_data;
          div_d      = w_div_clamped;
          pmode_d    = parity_mode_i;
          two_stop_d = two_stop_i;
          bit_d      = '0;
          stop_d     = 1'b0;
          state_d    = ST_START;
        end
      end
      ST_START: begin
        if (cnt_q == '0) tx_d = 1'b0;
        if (w_bit_end)   state_d = ST_DATA;
      end
      ST_DATA: begin
        if (cnt_q == '0) tx_d = shreg_q[0];
        if (w_bit_end) begin
          shreg_d = shreg_q >> 1;
          if (bit_q == BIT_W'(DATA_BITS - 1)) begin
            bit_d   = '0;
            state_d = parity_enabled(pmode_q) ? ST_PARITY : ST_STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      ST_PARITY: begin
        if (cnt_q == '0) tx_d = par_q;
        if (w_bit_end)   state_d = ST_STOP;
      end
      ST_STOP: begin
        if (cnt_q == '0) tx_d = 1'b1;
        if (w_bit_end) begin
          if (two_stop_q && !stop_q) begin
            stop_d = 1'b1;
          end else begin
            frame_done_d = 1'b1;
            state_d      = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      div_q        <= DIV_W'(MIN_DIV);
      bit_q        <= '0;
      shreg_q      <= '0;
      par_q        <= 1'b0;
      pmode_q      <= PAR_NONE;
      two_stop_q   <= 1'b0;
      stop_q       <= 1'b0;
      tx_q         <= 1'b1;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      div_q        <= div_d;
      bit_q        <= bit_d;
      shreg_q      <= shreg_d;
      par_q        <= par_d;
      pmode_q      <= pmode_d;
      two_stop_q   <= two_stop_d;
      stop_q       <= stop_d;
      tx_q         <= tx_d;
      frame_done_q <= frame_done_d;
      busy_q       <= (state_q != ST_IDLE) || !w_fifo_empty;
    end
  end

  assign in_ready_o   = !w_fifo_full;
  assign tx_o         = tx_q;
  assign busy_o       = busy_q;
  assign frame_done_o = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo_cfg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_uart_tx_fifo_cfg : directed self-checking bench for uart_tx_fifo_cfg.
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_uart_tx_fifo_cfg;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid, in_valid7;
  logic [7:0]  in_data;
  logic [6:0]  in_data7;
  logic        in_ready, in_ready7;
  logic [15:0] baud_div;
  logic [1:0]  parity_mode;
  logic        two_stop;
  logic        tx, tx7, busy, busy7, frame_done, frame_done7;
  logic [2:0]  fifo_level, fifo_level7;

  int   checks = 0;
  int   errors = 0;
  logic sel = 1'b0;
  logic w_tx, w_fd;
  logic [7:0] bw [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

  always #5 clk = ~clk;

  assign w_tx = sel ? tx7 : tx;
  assign w_fd = sel ? frame_done7 : frame_done;

  uart_tx_fifo_cfg #(.DATA_BITS(8), .FIFO_DEPTH(4), .DIV_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid_i(in_valid), .in_data_i(in_data),
    .in_ready_o(in_ready), .baud_div_i(baud_div), .parity_mode_i(parity_mode),
    .two_stop_i(two_stop), .tx_o(tx), .busy_o(busy), .frame_done_o(frame_done),
    .fifo_level_o(fifo_level)
  );

  uart_tx_fifo_cfg #(.DATA_BITS(7), .FIFO_DEPTH(4), .DIV_W(16)) dut7 (
    .clk(clk), .reset_n(reset_n), .in_valid_i(in_valid7), .in_data_i(in_data7),
    .in_ready_o(in_ready7), .baud_div_i(baud_div), .parity_mode_i(parity_mode),
    .two_stop_i(two_stop), .tx_o(tx7), .busy_o(busy7), .frame_done_o(frame_done7),
    .fifo_level_o(fifo_level7)
  );

  task automatic push(input logic [7:0] d);
    int   n;
    logic rdy;
    n   = 0;
    rdy = 1'b0;
    if (sel) begin in_valid7 = 1'b1; in_data7 = d[6:0]; end
    else     begin in_valid  = 1'b1; in_data  = d;      end
    while (!rdy && n < 1000) begin
      rdy = sel ? in_ready7 : in_ready;
      @(posedge clk); #1;
      n++;
    end
    in_valid  = 1'b0;
    in_valid7 = 1'b0;
    checks++;
    if (!rdy) begin
      errors++;
      $display("FAIL push: in_ready=0 for %0d cycles, required 1", n);
    end
  endtask

  // exp holds the whole frame, bit 0 = start bit, one entry per bit period.
  task automatic capture(input logic [15:0] exp, input int nbits, input int div,
                         input string name, output int waited);
    int          bad, fdc, fdp, len;
    logic [15:0] got, mask;
    bad = 0; fdc = 0; fdp = -1; got = '0; waited = 0;
    len  = nbits * div;
    mask = (16'h1 << nbits) - 16'h1;
    while (w_tx !== 1'b0 && waited < 20000) begin
      @(posedge clk); #1;
      waited++;
    end
    checks++;
    if (w_tx !== 1'b0) begin
      errors++;
      $display("FAIL %s start: tx never went low, got %b required 0", name, w_tx);
      return;
    end
    for (int k = 0; k < len; k++) begin
      if (w_tx !== exp[k / div]) bad++;
      if ((k % div) == (div / 2)) got[k / div] = w_tx;
      if (w_fd === 1'b1) begin fdc++; fdp = k; end
      if (k < len - 1) begin @(posedge clk); #1; end
    end
    checks++;
    if ((got & mask) !== (exp & mask)) begin
      errors++;
      $display("FAIL %s bits: got %h required %h", name, got & mask, exp & mask);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s timing: %0d cycles off, required 0", name, bad);
    end
    checks++;
    if (fdc != 1 || fdp != len - 1) begin
      errors++;
      $display("FAIL %s frame_done: %0d pulses at offset %0d, required 1 at %0d",
               name, fdc, fdp, len - 1);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({tx, in_ready, busy, frame_done, fifo_level} !== {1'b1, 1'b1, 1'b0, 1'b0, 3'd0}) begin
      errors++;
      $display("FAIL reset: tx/rdy/busy/fd/lvl=%b%b%b%b/%0d required 1110/0",
               tx, in_ready, busy, frame_done, fifo_level);
    end
    checks++;
    if ({tx7, in_ready7, busy7, frame_done7, fifo_level7} !== {1'b1, 1'b1, 1'b0, 1'b0, 3'd0}) begin
      errors++;
      $display("FAIL reset7: tx/rdy/busy/fd/lvl=%b%b%b%b/%0d required 1110/0",
               tx7, in_ready7, busy7, frame_done7, fifo_level7);
    end
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_8n1();
    int w;
    baud_div = 16'd434; parity_mode = 2'b00; two_stop = 1'b0;
    push(8'h41);
    capture(16'h0282, 10, 434, "8n1", w);
    checks++;
    if (w != 2) begin
      errors++;
      $display("FAIL latency: tx low %0d edges after accept, required 2", w);
    end
  endtask

  task automatic test_8e2();
    int w;
    baud_div = 16'd10; parity_mode = 2'b10; two_stop = 1'b1;
    push(8'hA5);
    capture(16'h0D4A, 12, 10, "8e2", w);
  endtask

  task automatic test_7o1();
    int w;
    sel = 1'b1;
    baud_div = 16'd6; parity_mode = 2'b01; two_stop = 1'b0;
    push(8'h03);
    capture(16'h0306, 10, 6, "7o1", w);
    sel = 1'b0;
  endtask

  task automatic test_back_to_back();
    int   idx, first_low, lowcnt, n;
    logic [2:0] lvl_at;
    logic done;
    baud_div = 16'd4; parity_mode = 2'b00; two_stop = 1'b0;
    first_low = -1; lvl_at = '0; lowcnt = 0; done = 1'b0;
    fork
      begin
        logic rdy;
        idx = 0;
        in_valid = 1'b1; in_data = bw[0];
        for (int c = 0; c < 2000 && idx < 6; c++) begin
          rdy = in_ready;
          if (!rdy && first_low < 0) begin first_low = idx; lvl_at = fifo_level; end
          @(posedge clk); #1;
          if (rdy) begin
            idx++;
            if (idx < 6) in_data = bw[idx];
          end
        end
        in_valid = 1'b0;
      end
      begin
        int wt;
        for (int i = 0; i < 6; i++) begin
          capture({5'd0, 1'b1, bw[i], 1'b0}, 10, 4, "burst", wt);
          if (i > 0) begin
            checks++;
            if (wt != 2) begin
              errors++;
              $display("FAIL burst gap %0d: start after %0d edges, required 2", i, wt);
            end
          end
        end
        done = 1'b1;
      end
      begin
        n = 0;
        repeat (2) @(posedge clk);
        #1;
        while (!done && n < 5000) begin
          if (busy !== 1'b1) lowcnt++;
          @(posedge clk); #1;
          n++;
        end
      end
    join
    checks++;
    if (first_low != 5) begin
      errors++;
      $display("FAIL burst accepts: in_ready low after %0d accepts, required 5", first_low);
    end
    checks++;
    if (lvl_at !== 3'd4) begin
      errors++;
      $display("FAIL burst level: fifo_level=%0d at full, required 4", lvl_at);
    end
    checks++;
    if (lowcnt != 0) begin
      errors++;
      $display("FAIL burst busy: low for %0d cycles, required 0", lowcnt);
    end
  endtask

  task automatic test_baud_change();
    baud_div = 16'd0; parity_mode = 2'b00; two_stop = 1'b0;
    fork
      begin
        push(8'h00);
        @(posedge clk); #1;
        baud_div = 16'd20;
        push(8'hFF);
      end
      begin
        int wt;
        capture(16'h0200, 10, 2, "div0", wt);
        capture(16'h03FE, 10, 20, "div20", wt);
        checks++;
        if (wt != 2) begin
          errors++;
          $display("FAIL div20 gap: start after %0d edges, required 2", wt);
        end
      end
    join
  endtask

  task automatic test_reset_mid();
    int badtx, badbusy;
    baud_div = 16'd10; parity_mode = 2'b00; two_stop = 1'b0;
    in_valid = 1'b1; in_data = 8'h00;
    repeat (4) begin @(posedge clk); #1; end
    in_valid = 1'b0;
    repeat (30) begin @(posedge clk); #1; end
    checks++;
    if (fifo_level !== 3'd3 || busy !== 1'b1 || tx !== 1'b0) begin
      errors++;
      $display("FAIL pre-reset: lvl=%0d busy=%b tx=%b, required 3 1 0", fifo_level, busy, tx);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({tx, in_ready, busy, frame_done, fifo_level} !== {1'b1, 1'b1, 1'b0, 1'b0, 3'd0}) begin
      errors++;
      $display("FAIL mid reset: tx/rdy/busy/fd/lvl=%b%b%b%b/%0d required 1110/0",
               tx, in_ready, busy, frame_done, fifo_level);
    end
    @(posedge clk); #2;
    reset_n = 1'b1;
    badtx = 0; badbusy = 0;
    repeat (200) begin
      @(posedge clk); #1;
      if (tx !== 1'b1)   badtx++;
      if (busy !== 1'b0) badbusy++;
    end
    checks++;
    if (badtx != 0) begin
      errors++;
      $display("FAIL stale frame: tx low %0d cycles after reset, required 0", badtx);
    end
    checks++;
    if (badbusy != 0) begin
      errors++;
      $display("FAIL post-reset busy: high %0d cycles, required 0", badbusy);
    end
  endtask

  initial begin
    in_valid = 1'b0; in_valid7 = 1'b0; in_data = '0; in_data7 = '0;
    baud_div = 16'd2; parity_mode = 2'b00; two_stop = 1'b0;
    #1;
    test_reset();
    test_8n1();
    test_8e2();
    test_7o1();
    test_back_to_back();
    test_baud_change();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
